// File: rtl/diff_avg_decimator.sv
// diff_avg_decimator
//   Second-difference filter with half-wave rectification, N-sample moving
//   average (N = 2^DEPTH_LOG2, running-sum form) and decimation by DEC.
//   Placed between the input sampler and downstream packet/display logic.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-low
//   SCLR       synchronous clear, same effect as reset, wins over EN
//   EN         sample enable; IN is accepted on an edge where EN=1
//   IN         unsigned input sample, IN_W bits
//   OUT        decimated, saturated average; holds between strobes
//   OUT_VALID  one-cycle strobe marking a new OUT
module diff_avg_decimator #(
  parameter int IN_W       = 1,
  parameter int OUT_W      = 8,
  parameter int DEPTH_LOG2 = 6,
  parameter int DEC        = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCLR,
  input  logic             EN,
  input  logic [IN_W-1:0]  IN,
  output logic [OUT_W-1:0] OUT,
  output logic             OUT_VALID
);

  localparam int N      = 1 << DEPTH_LOG2;
  localparam int R_W    = IN_W + 1;
  localparam int D_W    = IN_W + 3;
  localparam int S_W    = IN_W + 1 + DEPTH_LOG2;
  localparam int WP_W   = DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam int DC_W   = (DEC > 1) ? $clog2(DEC) : 1;

  logic [IN_W-1:0]   x1;
  logic [IN_W-1:0]   x2;
  logic [R_W-1:0]    win_buf [N];
  logic [S_W-1:0]    sum;
  logic [WP_W-1:0]   wp;
  logic [DC_W-1:0]   dc;
  logic [FILL_W-1:0] fill;
  logic              primed;
  logic              fire;

  logic signed [D_W-1:0] d;
  logic [R_W-1:0]        r;
  logic [FILL_W-1:0]     fill_nx;
  logic                  primed_nx;
  logic                  dc_last;
  logic                  wp_last;
  logic [R_W-1:0]        avg;
  logic [OUT_W-1:0]      avg_sat;

  always_comb begin
    d = $signed({3'b000, IN}) - $signed({2'b00, x1, 1'b0}) + $signed({3'b000, x2});
    r = '0;
    // Positive d is at most 2*(2^IN_W-1), so the low R_W bits carry it exactly.
    if (!d[D_W-1] && (d != '0)) r = d[R_W-1:0];
    fill_nx   = (fill == FILL_W'(N)) ? fill : fill + FILL_W'(1);
    primed_nx = primed | (fill_nx == FILL_W'(N));
    dc_last   = (dc == DC_W'(DEC - 1));
    wp_last   = (wp == WP_W'(N - 1));
    avg       = R_W'(sum >> DEPTH_LOG2);
  end

  generate
    if (OUT_W >= R_W) begin : g_nosat
      assign avg_sat = OUT_W'(avg);
    end else begin : g_sat
      assign avg_sat = (|avg[R_W-1:OUT_W]) ? '1 : avg[OUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      x1        <= '0;
      x2        <= '0;
      sum       <= '0;
      wp        <= '0;
      dc        <= '0;
      fill      <= '0;
      primed    <= 1'b0;
      fire      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) win_buf[i] <= '0;
    end else if (SCLR) begin
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      x1        <= '0;
      x2        <= '0;
      sum       <= '0;
      wp        <= '0;
      dc        <= '0;
      fill      <= '0;
      primed    <= 1'b0;
      fire      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) win_buf[i] <= '0;
    end else begin
      // Output stage reads the sum as left by the firing edge; a sample
      // accepted on this same edge only affects the next average.
      OUT_VALID <= fire;
      if (fire) OUT <= avg_sat;
      fire <= 1'b0;
      if (EN) begin
        x2          <= x1;
        x1          <= IN;
        win_buf[wp] <= r;
        sum         <= sum + S_W'(r) - S_W'(win_buf[wp]);
        wp          <= wp_last ? '0 : wp + WP_W'(1);
        dc          <= dc_last ? '0 : dc + DC_W'(1);
        fill        <= fill_nx;
        primed      <= primed_nx;
        fire        <= dc_last && primed_nx;
      end
    end
  end

endmodule

// File: tb/tb_diff_avg_decimator.sv
module tb_diff_avg_decimator;

  logic       CLK  = 1'b0;
  logic       RST  = 1'b0;
  logic       SCLR = 1'b0;
  logic       EN   = 1'b0;
  logic [7:0] IN   = '0;

  logic [7:0] out0;
  logic [3:0] out1;
  logic [7:0] out2;
  logic       v0, v1, v2;
  logic [7:0] outs [3];
  logic       vld  [3];

  assign outs[0] = out0;
  assign outs[1] = {4'b0000, out1};
  assign outs[2] = out2;
  assign vld[0]  = v0;
  assign vld[1]  = v1;
  assign vld[2]  = v2;

  always #5 CLK = ~CLK;

  // dut0: N=64, DEC=64, OUT_W=8
  diff_avg_decimator #(.IN_W(8), .OUT_W(8), .DEPTH_LOG2(6), .DEC(64)) dut0 (
    .CLK(CLK), .RST(RST), .SCLR(SCLR), .EN(EN), .IN(IN), .OUT(out0), .OUT_VALID(v0));
  // dut1: saturating 4-bit output
  diff_avg_decimator #(.IN_W(8), .OUT_W(4), .DEPTH_LOG2(6), .DEC(64)) dut1 (
    .CLK(CLK), .RST(RST), .SCLR(SCLR), .EN(EN), .IN(IN), .OUT(out1), .OUT_VALID(v1));
  // dut2: N=4, DEC=1
  diff_avg_decimator #(.IN_W(8), .OUT_W(8), .DEPTH_LOG2(2), .DEC(1)) dut2 (
    .CLK(CLK), .RST(RST), .SCLR(SCLR), .EN(EN), .IN(IN), .OUT(out2), .OUT_VALID(v2));

  localparam int DLOG [3] = '{6, 6, 2};
  localparam int DECV [3] = '{64, 64, 1};
  localparam int OW   [3] = '{8, 4, 8};

  typedef struct {
    int dut;
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q  [$];
  ev_t seen_q [$];
  int  r_hist [$];
  int  cnt;
  int  mx1, mx2;
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void model_clear();
    r_hist.delete();
    exp_q.delete();
    cnt = 0;
    mx1 = 0;
    mx2 = 0;
  endfunction

  // Reference: keeps the full rectified history and re-sums the last N
  // entries whenever a decimation point is reached.
  function automatic void model_accept(int x, int edge_c);
    int dd, rr, n, sum, avg, lim;
    dd = x - 2 * mx1 + mx2;
    rr = (dd > 0) ? dd : 0;
    mx2 = mx1;
    mx1 = x;
    r_hist.push_back(rr);
    if (r_hist.size() > 64) void'(r_hist.pop_front());
    cnt++;
    for (int k = 0; k < 3; k++) begin
      n = 1 << DLOG[k];
      if ((cnt % DECV[k]) == 0 && cnt >= n) begin
        sum = 0;
        for (int i = 0; i < n; i++) sum += r_hist[r_hist.size() - 1 - i];
        avg = sum >> DLOG[k];
        lim = (1 << OW[k]) - 1;
        if (avg > lim) avg = lim;
        exp_q.push_back('{k, avg, edge_c + 1});
      end
    end
  endfunction

  // One cycle of stimulus, applied just after the falling edge.
  task automatic drive(input logic en, input logic [7:0] x, input logic sclr);
    @(negedge CLK);
    #1;
    EN   = en;
    IN   = x;
    SCLR = sclr;
    if (sclr) model_clear();
    else if (en && RST) model_accept(int'(x), cyc + 1);
  endtask

  task automatic monitor();
    int idx;
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].dut == k) idx = i;
        if (vld[k]) begin
          seen_q.push_back('{k, int'(outs[k]), cyc});
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL sb_unexpected dut%0d: strobe OUT=%0d at cycle %0d, required no strobe",
                     k, outs[k], cyc);
          end else begin
            if (int'(outs[k]) !== exp_q[idx].val || cyc !== exp_q[idx].cyc) begin
              errors++;
              $display("FAIL sb_strobe dut%0d: OUT=%0d at cycle %0d, required OUT=%0d at cycle %0d",
                       k, outs[k], cyc, exp_q[idx].val, exp_q[idx].cyc);
            end
            exp_q.delete(idx);
          end
        end else if (idx >= 0 && exp_q[idx].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL sb_missing dut%0d: no strobe at cycle %0d, required OUT=%0d",
                   k, cyc, exp_q[idx].val);
          exp_q.delete(idx);
        end
      end
    end
  endtask

  task automatic test_reset();
    int n;
    model_clear();
    RST = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      #1;
      EN = 1'($urandom_range(0, 1));
      IN = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (outs[k] !== 8'd0 || vld[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_dut%0d: OUT=%0d OUT_VALID=%0b, required 0/0", k, outs[k], vld[k]);
        end
      end
    end
    EN  = 1'b0;
    RST = 1'b1;
    n   = 0;
    repeat (100) begin
      drive(1'b0, 8'($urandom), 1'b0);
      for (int k = 0; k < 3; k++) if (vld[k]) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL idle_no_strobe: %0d strobes with EN=0, required 0", n);
    end
  endtask

  task automatic test_alternating();
    int t0;
    int v[$];
    int c[$];
    drive(1'b0, 8'd0, 1'b1);
    seen_q.delete();
    t0 = cyc + 1;
    for (int i = 1; i <= 128; i++) drive(1'b1, (i % 2) ? 8'd255 : 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    foreach (seen_q[i]) if (seen_q[i].dut == 0) begin
      v.push_back(seen_q[i].val);
      c.push_back(seen_q[i].cyc);
    end
    checks++;
    if (v.size() !== 2) begin
      errors++;
      $display("FAIL alt_count: %0d strobes, required 2", v.size());
    end
    while (v.size() < 2) begin v.push_back(-1); c.push_back(-1); end
    checks++;
    if (v[0] !== 251 || c[0] !== t0 + 65) begin
      errors++;
      $display("FAIL alt_first: OUT=%0d cycle=%0d, required 251 cycle=%0d", v[0], c[0], t0 + 65);
    end
    checks++;
    if (v[1] !== 255 || c[1] !== t0 + 129) begin
      errors++;
      $display("FAIL alt_second: OUT=%0d cycle=%0d, required 255 cycle=%0d", v[1], c[1], t0 + 129);
    end
  endtask

  task automatic test_saturation();
    int n;
    drive(1'b0, 8'd0, 1'b1);
    seen_q.delete();
    for (int i = 1; i <= 128; i++) drive(1'b1, (i % 2) ? 8'd255 : 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    n = 0;
    foreach (seen_q[i]) if (seen_q[i].dut == 1) begin
      n++;
      checks++;
      if (seen_q[i].val !== 15) begin
        errors++;
        $display("FAIL sat_value: OUT=%0d, required 15", seen_q[i].val);
      end
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL sat_count: %0d strobes, required 2", n);
    end
  endtask

  task automatic test_en_gating();
    int t0;
    int v[$];
    int c[$];
    drive(1'b0, 8'd0, 1'b1);
    seen_q.delete();
    t0 = cyc + 1;
    for (int i = 1; i <= 128; i++) begin
      drive(1'b1, (i % 2) ? 8'd255 : 8'd0, 1'b0);
      drive(1'b0, 8'($urandom), 1'b0);
    end
    drive(1'b0, 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    foreach (seen_q[i]) if (seen_q[i].dut == 0) begin
      v.push_back(seen_q[i].val);
      c.push_back(seen_q[i].cyc);
    end
    checks++;
    if (v.size() !== 2) begin
      errors++;
      $display("FAIL en_count: %0d strobes, required 2", v.size());
    end
    while (v.size() < 2) begin v.push_back(-1); c.push_back(-1); end
    checks++;
    if (v[0] !== 251 || c[0] !== t0 + 128) begin
      errors++;
      $display("FAIL en_first: OUT=%0d cycle=%0d, required 251 cycle=%0d", v[0], c[0], t0 + 128);
    end
    checks++;
    if (v[1] !== 255 || c[1] !== t0 + 256) begin
      errors++;
      $display("FAIL en_second: OUT=%0d cycle=%0d, required 255 cycle=%0d", v[1], c[1], t0 + 256);
    end
  endtask

  task automatic test_sclr();
    int t0;
    int v[$];
    int c[$];
    for (int i = 1; i <= 40; i++) drive(1'b1, (i % 2) ? 8'd255 : 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b1);
    seen_q.delete();
    t0 = cyc + 1;
    for (int i = 1; i <= 64; i++) begin
      drive(1'b1, (i % 2) ? 8'd255 : 8'd0, 1'b0);
      if (i == 1) begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (outs[k] !== 8'd0 || vld[k] !== 1'b0) begin
            errors++;
            $display("FAIL sclr_clear_dut%0d: OUT=%0d OUT_VALID=%0b, required 0/0", k, outs[k], vld[k]);
          end
        end
      end
    end
    drive(1'b0, 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    foreach (seen_q[i]) if (seen_q[i].dut == 0) begin
      v.push_back(seen_q[i].val);
      c.push_back(seen_q[i].cyc);
    end
    while (v.size() < 1) begin v.push_back(-1); c.push_back(-1); end
    checks++;
    if (v[0] !== 251 || c[0] !== t0 + 65) begin
      errors++;
      $display("FAIL sclr_restart: OUT=%0d cycle=%0d, required 251 cycle=%0d", v[0], c[0], t0 + 65);
    end
    // Next 64 samples set a pending fire; SCLR on the following edge kills it.
    for (int i = 65; i <= 128; i++) drive(1'b1, (i % 2) ? 8'd255 : 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b1);
    drive(1'b0, 8'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (vld[k] !== 1'b0 || outs[k] !== 8'd0) begin
        errors++;
        $display("FAIL sclr_pending_dut%0d: OUT=%0d OUT_VALID=%0b, required 0/0", k, outs[k], vld[k]);
      end
    end
  endtask

  task automatic test_dec1();
    int t0;
    int v[$];
    int c[$];
    drive(1'b0, 8'd0, 1'b1);
    seen_q.delete();
    t0 = cyc + 1;
    for (int i = 1; i <= 6; i++) drive(1'b1, (i % 2) ? 8'd255 : 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    foreach (seen_q[i]) if (seen_q[i].dut == 2) begin
      v.push_back(seen_q[i].val);
      c.push_back(seen_q[i].cyc);
    end
    checks++;
    if (v.size() !== 3) begin
      errors++;
      $display("FAIL dec1_count: %0d strobes, required 3", v.size());
    end
    while (v.size() < 3) begin v.push_back(-1); c.push_back(-1); end
    checks++;
    if (v[0] !== 191 || c[0] !== t0 + 5) begin
      errors++;
      $display("FAIL dec1_first: OUT=%0d cycle=%0d, required 191 cycle=%0d", v[0], c[0], t0 + 5);
    end
    checks++;
    if (v[1] !== 255 || c[1] !== t0 + 6) begin
      errors++;
      $display("FAIL dec1_second: OUT=%0d cycle=%0d, required 255 cycle=%0d", v[1], c[1], t0 + 6);
    end
    checks++;
    if (v[2] !== 255 || c[2] !== t0 + 7) begin
      errors++;
      $display("FAIL dec1_third: OUT=%0d cycle=%0d, required 255 cycle=%0d", v[2], c[2], t0 + 7);
    end
  endtask

  initial begin
    model_clear();
    fork
      monitor();
    join_none
    test_reset();
    test_alternating();
    test_saturation();
    test_en_gating();
    test_sclr();
    test_dec1();
    repeat (3) drive(1'b0, 8'd0, 1'b0);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected strobes never seen, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
